uart_frame_tx: RTL



---
 rtl/uart_pkg.sv | 29 ++
 rtl/sync_fifo.sv | 67 ++++++
 rtl/uart_frame_tx.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   tx_state_e  : frame FSM state encoding (3-bit enum)
//   PAR_EVEN/ODD: parity-type encodings as seen on the PAR_TYP input
//   calc_parity : parity bit for a data word of up to MAX_WD bits
package uart_pkg;

  // Widest payload supported.
  localparam int MAX_WD = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP1  = 3'd4,
    ST_STOP2  = 3'd5
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Narrower words are zero-extended by the caller. Zero bits do not
  // change the XOR, so one function serves every legal width.
  function automatic logic calc_parity(input logic [MAX_WD-1:0] data,
                                       input logic              par_typ);
    return (par_typ == PAR_ODD) ? ~(^data) : (^data);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word fall-through. rdata always shows the
// head entry, so a consumer can pop and use the word on the same edge.
// Ports:
//   clk    in   clock
//   rst    in   synchronous active-low reset (flushes the FIFO)
//   push   in   write wdata; ignored while full, even if popping
//   wdata  in   WIDTH-bit write data
//   pop    in   remove head entry; ignored while empty
//   rdata  out  head entry (valid when !empty)
//   full   out  DEPTH entries stored
//   empty  out  no entries stored
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // Full is judged before any same-edge pop, so a push against a full
  // FIFO is always dropped.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (rst && do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_frame_tx.sv
// UART transmitter with an input FIFO and per-frame configuration.
// Frame: start (0), DATA_WD bits LSB first, optional parity, 1 or 2 stops.
// Ports:
//   UART_TX_clck in   bit clock, one UART bit per cycle
//   rst          in   synchronous active-low reset; aborts frame, flushes FIFO
//   P_DATA       in   payload word pushed into the FIFO
//   DATA_VALID   in   push request (accepted when READY)
//   PAR_EN       in   parity bit present       (latched when a word is popped)
//   PAR_TYP      in   0 = even, 1 = odd parity (latched when a word is popped)
//   STOP2        in   two stop bits            (latched when a word is popped)
//   READY        out  FIFO not full
//   TX_OUT       out  serial line, idles high (registered)
//   BUSY         out  frame in progress (registered)
//   FRAME_DONE   out  high during the final stop-bit cycle (registered)
module uart_frame_tx
  import uart_pkg::*;
#(
  parameter int DATA_WD    = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               UART_TX_clck,
  input  logic               rst,
  input  logic [DATA_WD-1:0] P_DATA,
  input  logic               DATA_VALID,
  input  logic               PAR_EN,
  input  logic               PAR_TYP,
  input  logic               STOP2,
  output logic               READY,
  output logic               TX_OUT,
  output logic               BUSY,
  output logic               FRAME_DONE
);

  localparam int                 CNT_W    = $clog2(DATA_WD);
  localparam logic [CNT_W-1:0]   LAST_BIT = CNT_W'(DATA_WD - 1);

  tx_state_e          state;
  tx_state_e          next_state;
  logic [DATA_WD-1:0] shift_reg;
  logic [DATA_WD-1:0] shift_next;
  logic [CNT_W-1:0]   bit_cnt;
  logic               cfg_par_en;
  logic               cfg_stop2;
  logic               par_bit;
  logic               fifo_full;
  logic               fifo_empty;
  logic [DATA_WD-1:0] fifo_rdata;
  logic               frame_end;
  logic               load;
  logic               tx_d;
  logic               busy_d;
  logic               done_d;

  sync_fifo #(
    .WIDTH (DATA_WD),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (UART_TX_clck),
    .rst   (rst),
    .push  (DATA_VALID),
    .wdata (P_DATA),
    .pop   (load),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign READY = !fifo_full;

  // The last stop-bit cycle doubles as the idle check, which is what lets
  // the next start bit follow with no gap.
  assign frame_end = ((state == ST_STOP1) && !cfg_stop2) || (state == ST_STOP2);
  assign load      = ((state == ST_IDLE) || frame_end) && !fifo_empty;

  // State register, datapath registers and output flops. The outputs are
  // loaded from values decoded for the next state so that they come
  // straight from flops.
  always_ff @(posedge UART_TX_clck) begin
    if (!rst) begin
      state      <= ST_IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      cfg_par_en <= 1'b0;
      cfg_stop2  <= 1'b0;
      par_bit    <= 1'b0;
      TX_OUT     <= 1'b1;
      BUSY       <= 1'b0;
      FRAME_DONE <= 1'b0;
    end else begin
      state      <= next_state;
      shift_reg  <= shift_next;
      TX_OUT     <= tx_d;
      BUSY       <= busy_d;
      FRAME_DONE <= done_d;
      if (load) begin
        bit_cnt    <= '0;
        cfg_par_en <= PAR_EN;
        cfg_stop2  <= STOP2;
        par_bit    <= calc_parity(MAX_WD'(fifo_rdata), PAR_TYP);
      end else if (state == ST_DATA) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end
  end

  // Next-state logic. The shift register shifts while in DATA so that
  // bit 0 always holds the bit for the upcoming data cycle.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:   if (!fifo_empty) next_state = ST_START;
      ST_START:  next_state = ST_DATA;
      ST_DATA:   if (bit_cnt == LAST_BIT)
                   next_state = cfg_par_en ? ST_PARITY : ST_STOP1;
      ST_PARITY: next_state = ST_STOP1;
      ST_STOP1:  if (cfg_stop2)        next_state = ST_STOP2;
                 else if (fifo_empty)  next_state = ST_IDLE;
                 else                  next_state = ST_START;
      ST_STOP2:  next_state = fifo_empty ? ST_IDLE : ST_START;
      default:   next_state = ST_IDLE;
    endcase

    shift_next = shift_reg;
    if (load)                   shift_next = fifo_rdata;
    else if (state == ST_DATA)  shift_next = shift_reg >> 1;
  end

  // Output decode for the state being entered. next_state never enters a
  // parity or stop state on a load edge, so the latched config is the one
  // belonging to that frame.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (next_state != ST_IDLE);
    done_d = 1'b0;
    case (next_state)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_next[0];
      ST_PARITY: tx_d = par_bit;
      ST_STOP1:  done_d = !cfg_stop2;
      ST_STOP2:  done_d = 1'b1;
      default:   tx_d = 1'b1;
    endcase
  end

endmodule
